fetch_unit: RTL

Instruction fetch stage that sits directly upstream of the single-cycle cpu. It turns the cpu's byte-addressed PC into the 16-bit instruction on cpu Iin, fetching two bytes over a byte-wide request/acknowledge memory bus. A one-entry instruction latch (tag = PC) covers repeated fetches of the same PC, for example during halt. STALL is asserted while no valid instruction is available; the cpu must hold its state while STALL = 1.

---
 rtl/fetch_unit_pkg.sv | 19 +
 rtl/fetch_timeout_counter.sv | 40 ++++
 rtl/fetch_unit.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg
// Shared definitions for the instruction fetch stage: FSM state encoding,
// default widths and the instruction driven while nothing valid is available.
// No ports.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ_HI  = 2'd1,
        REQ_LO  = 2'd2,
        FAULTED = 2'd3
    } fetch_state_t;

    localparam int          FETCH_ADDR_W   = 8;
    localparam int          FETCH_TIMEOUT  = 255;
    localparam logic [15:0] FETCH_NOP_INST = 16'h0000;
    localparam int          WAIT_CNT_W     = 8;

endpackage

// File: rtl/fetch_timeout_counter.sv
// fetch_timeout_counter
// Per-beat wait counter for the fetch FSM. The count holds the index of the
// current cycle within a memory beat (1 on the first cycle of the beat), so
// at_limit is raised during the TIMEOUT-th cycle the beat has gone unacked.
// Ports:
//   CLK      in   system clock, rising edge
//   RESET_L  in   synchronous active-low reset
//   load     in   a new beat starts next cycle; count restarts at 1
//   count_en in   current beat cycle was not acked; advance (saturating)
//   at_limit out  count equals TIMEOUT (never raised when TIMEOUT = 0)
module fetch_timeout_counter
    import fetch_unit_pkg::*;
#(
    parameter int TIMEOUT = FETCH_TIMEOUT
) (
    input  logic CLK,
    input  logic RESET_L,
    input  logic load,
    input  logic count_en,
    output logic at_limit
);

    localparam logic [WAIT_CNT_W-1:0] LIMIT   = WAIT_CNT_W'(TIMEOUT);
    localparam logic [WAIT_CNT_W-1:0] CNT_MAX = '1;

    logic [WAIT_CNT_W-1:0] wait_cnt;

    always_ff @(posedge CLK) begin
        if (!RESET_L) begin
            wait_cnt <= '0;
        end else if (load) begin
            wait_cnt <= WAIT_CNT_W'(1);
        end else if (count_en && (wait_cnt != CNT_MAX)) begin
            wait_cnt <= wait_cnt + WAIT_CNT_W'(1);
        end
    end

    assign at_limit = (TIMEOUT != 0) && (wait_cnt == LIMIT);

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit
// Instruction fetch stage in front of the single-cycle cpu. Fetches the
// 16-bit big-endian instruction at PC as two byte beats over a req/ack bus
// and keeps the last completed word in a one-entry latch tagged by PC.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no fetch in flight; hit serves latch, even miss starts fetch
// REQ_HI  | requesting byte at FPC, result goes to the high byte
// REQ_LO  | requesting byte at FPC+1, completion fills the latch
// FAULTED | odd PC or ack timeout seen; held until reset
//
// Ports:
//   CLK, RESET_L    clock and synchronous active-low reset
//   PC              byte address the cpu wants (must be even)
//   INST/INST_VALID instruction for cpu Iin and its validity for PC
//   STALL           cpu must hold its state this cycle
//   FAULT           sticky error flag
//   MEM_REQ/MEM_ADDR registered byte read request and address
//   MEM_ACK/MEM_RDATA read acknowledge and returned byte
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int          ADDR_W   = FETCH_ADDR_W,
    parameter int          TIMEOUT  = FETCH_TIMEOUT,
    parameter logic [15:0] NOP_INST = FETCH_NOP_INST
) (
    input  logic              CLK,
    input  logic              RESET_L,
    input  logic [ADDR_W-1:0] PC,
    output logic [15:0]       INST,
    output logic              INST_VALID,
    output logic              STALL,
    output logic              FAULT,
    output logic              MEM_REQ,
    output logic [ADDR_W-1:0] MEM_ADDR,
    input  logic              MEM_ACK,
    input  logic [7:0]        MEM_RDATA
);

    fetch_state_t      state, state_next;
    logic [ADDR_W-1:0] fpc;
    logic [ADDR_W-1:0] tag;
    logic              tag_valid;
    logic [7:0]        hi_byte;
    logic [15:0]       inst_word;

    logic              hit;
    logic              capture_pc;
    logic              take_hi;
    logic              take_lo;
    logic              req_next;
    logic [ADDR_W-1:0] addr_next;
    logic              cnt_load;
    logic              cnt_en;
    logic              at_limit;

    // Combinational from PC so a taken branch to a latched address costs
    // nothing. A faulted unit never reports a hit.
    assign hit        = tag_valid && (PC == tag) && (state != FAULTED);
    assign INST_VALID = hit;
    assign INST       = hit ? inst_word : NOP_INST;
    assign STALL      = !hit;
    assign FAULT      = (state == FAULTED);

    fetch_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .CLK      (CLK),
        .RESET_L  (RESET_L),
        .load     (cnt_load),
        .count_en (cnt_en),
        .at_limit (at_limit)
    );

    always_ff @(posedge CLK) begin
        if (!RESET_L) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Beats only leave their state on an ack (or timeout), so an in-flight
    // fetch always completes against FPC regardless of what PC does.
    always_comb begin
        state_next = state;
        capture_pc = 1'b0;
        take_hi    = 1'b0;
        take_lo    = 1'b0;
        req_next   = MEM_REQ;
        addr_next  = MEM_ADDR;
        cnt_load   = 1'b0;
        cnt_en     = 1'b0;
        case (state)
            IDLE: begin
                if (!hit) begin
                    if (PC[0]) begin
                        state_next = FAULTED;
                    end else begin
                        state_next = REQ_HI;
                        capture_pc = 1'b1;
                        req_next   = 1'b1;
                        addr_next  = PC;
                        cnt_load   = 1'b1;
                    end
                end
            end
            REQ_HI: begin
                if (MEM_ACK) begin
                    state_next = REQ_LO;
                    take_hi    = 1'b1;
                    addr_next  = fpc + ADDR_W'(1);
                    cnt_load   = 1'b1;
                end else if (at_limit) begin
                    state_next = FAULTED;
                    req_next   = 1'b0;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            REQ_LO: begin
                if (MEM_ACK) begin
                    state_next = IDLE;
                    take_lo    = 1'b1;
                    req_next   = 1'b0;
                end else if (at_limit) begin
                    state_next = FAULTED;
                    req_next   = 1'b0;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            FAULTED: begin
                req_next = 1'b0;
            end
            default: begin
                state_next = IDLE;
                req_next   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET_L) begin
            MEM_REQ   <= 1'b0;
            MEM_ADDR  <= '0;
            fpc       <= '0;
            tag       <= '0;
            tag_valid <= 1'b0;
            hi_byte   <= '0;
            inst_word <= '0;
        end else begin
            MEM_REQ  <= req_next;
            MEM_ADDR <= addr_next;
            if (capture_pc) begin
                fpc <= PC;
            end
            if (take_hi) begin
                hi_byte <= MEM_RDATA;
            end
            if (take_lo) begin
                inst_word <= {hi_byte, MEM_RDATA};
                tag       <= fpc;
                tag_valid <= 1'b1;
            end
        end
    end

endmodule
